// File: rtl/rfg_spi_cmd_sequencer_if.sv
// rfg_spi_cmd_sequencer_if: AXIS byte ingress from SPI and read-back egress towards SPI.
interface rfg_spi_cmd_sequencer_if #(
   parameter int ID_WIDTH = 8
);
   logic [7:0]          s_axis_tdata;
   logic                s_axis_tvalid;
   logic                s_axis_tready;
   logic [ID_WIDTH-1:0] s_axis_tid;
   logic [7:0]          m_axis_tdata;
   logic                m_axis_tvalid;
   logic                m_axis_tready;
   logic                m_axis_tlast;
   logic [ID_WIDTH-1:0] m_axis_tdest;
   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
   );
   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
   );
endinterface

// File: rtl/rfg_spi_cmd_sequencer.sv
// rfg_spi_cmd_sequencer: decodes SPI command bytes into register-file write/read strobes
// and streams read data back to the originating source.
module rfg_spi_cmd_sequencer #(
   parameter int ADDR_WIDTH = 8,
   parameter int ID_WIDTH   = 8,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  resn,
   rfg_spi_cmd_sequencer_if.slave axis,
   output logic [ADDR_WIDTH-1:0] rfg_address,
   output logic                  rfg_write,
   output logic [7:0]            rfg_writedata,
   output logic                  rfg_read,
   input  logic [7:0]            rfg_readdata,
   input  logic                  rfg_readdata_valid,
   output logic                  busy,
   output logic                  err_cmd,
   output logic                  err_timeout
);
   localparam int IW = $clog2(TIMEOUT);
   typedef enum logic [2:0] {CMD, ADDR, LEN, WDATA, RREQ, RWAIT, RSEND} state_t;
   state_t state;
   logic is_read, auto_inc, hs, timed;
   logic [7:0] rem;
   logic [IW-1:0] idle;
   assign axis.s_axis_tready = state inside {CMD, ADDR, LEN, WDATA};
   assign hs = axis.s_axis_tvalid && axis.s_axis_tready;
   assign timed = state inside {ADDR, LEN, WDATA, RWAIT};
   assign busy = state != CMD;
   always_ff @(posedge clk) begin
      if (!resn) begin
         state              <= CMD;
         is_read            <= 1'b0;
         auto_inc           <= 1'b0;
         rem                <= '0;
         idle               <= '0;
         rfg_address        <= '0;
         rfg_write          <= 1'b0;
         rfg_writedata      <= '0;
         rfg_read           <= 1'b0;
         axis.m_axis_tdata  <= '0;
         axis.m_axis_tvalid <= 1'b0;
         axis.m_axis_tlast  <= 1'b0;
         axis.m_axis_tdest  <= '0;
         err_cmd            <= 1'b0;
         err_timeout        <= 1'b0;
      end else begin
         rfg_write   <= 1'b0;
         rfg_read    <= 1'b0;
         err_cmd     <= 1'b0;
         err_timeout <= 1'b0;
         idle        <= (timed && !hs) ? idle + IW'(1) : '0;
         // write address advances once the strobe it belongs to has been issued
         if (rfg_write && auto_inc) rfg_address <= rfg_address + ADDR_WIDTH'(1);
         unique case (state)
            CMD: if (hs) begin
               is_read           <= axis.s_axis_tdata[7];
               auto_inc          <= axis.s_axis_tdata[5];
               axis.m_axis_tdest <= axis.s_axis_tid;
               err_cmd           <= axis.s_axis_tdata[7:6] == 2'b11;
               state             <= (axis.s_axis_tdata[7:6] == 2'b01 || axis.s_axis_tdata[7:6] == 2'b10) ? ADDR : CMD;
            end
            ADDR: if (hs) begin
               rfg_address <= ADDR_WIDTH'(axis.s_axis_tdata);
               state       <= LEN;
            end
            LEN: if (hs) begin
               rem      <= axis.s_axis_tdata;
               rfg_read <= is_read && axis.s_axis_tdata != 8'd0;
               state    <= (axis.s_axis_tdata == 8'd0) ? CMD : (is_read ? RREQ : WDATA);
            end
            WDATA: if (hs) begin
               rfg_write     <= 1'b1;
               rfg_writedata <= axis.s_axis_tdata;
               rem           <= rem - 8'd1;
               state         <= (rem == 8'd1) ? CMD : WDATA;
            end
            RREQ: state <= RWAIT;
            RWAIT: if (rfg_readdata_valid) begin
               axis.m_axis_tdata  <= rfg_readdata;
               axis.m_axis_tvalid <= 1'b1;
               axis.m_axis_tlast  <= rem == 8'd1;
               state              <= RSEND;
            end
            RSEND: if (axis.m_axis_tready) begin
               axis.m_axis_tvalid <= 1'b0;
               axis.m_axis_tlast  <= 1'b0;
               rem                <= rem - 8'd1;
               rfg_address        <= auto_inc ? rfg_address + ADDR_WIDTH'(1) : rfg_address;
               rfg_read           <= rem != 8'd1;
               state              <= (rem == 8'd1) ? CMD : RREQ;
            end
            default: state <= CMD;
         endcase
         // arriving read data wins over a coincident expiry
         if (timed && !hs && !(state == RWAIT && rfg_readdata_valid) && idle == IW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= CMD;
         end
      end
   end
endmodule

// File: doc/rfg_spi_cmd_sequencer.md
Name: rfg_spi_cmd_sequencer

Overview:
- Consumes the byte stream produced by the SPI slave ingress AXIS port (MSB-first bytes, tid tagged) and decodes register-file commands.
- Sequences single-cycle register-file write and read strobes, with optional address auto-increment.
- Returns read data as an AXIS byte stream routed back to the originating source.
- Sits between the SPI ingress/egress pair and the register file (rfg), in the system clock domain after the CDC FIFO.

Parameters:
- ADDR_WIDTH, 8, register address width; address arithmetic wraps modulo 2^ADDR_WIDTH.
- ID_WIDTH, 8, width of s_axis_tid and m_axis_tdest.
- TIMEOUT, 1024, idle cycles tolerated mid-command before abort; must be at least 2.

Ports:
- clk  in  1  system clock
- resn  in  1  synchronous active-low reset
- s_axis_tdata  in  8  command/payload byte from SPI ingress
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  sequencer accepts byte
- s_axis_tid  in  ID_WIDTH  source id of byte
- m_axis_tdata  out  8  read-back byte
- m_axis_tvalid  out  1  read-back valid
- m_axis_tready  in  1  egress ready
- m_axis_tlast  out  1  last byte of read burst
- m_axis_tdest  out  ID_WIDTH  destination = tid latched from command byte
- rfg_address  out  ADDR_WIDTH  register address
- rfg_write  out  1  one-cycle write strobe
- rfg_writedata  out  8  write data
- rfg_read  out  1  one-cycle read strobe
- rfg_readdata  in  8  read data
- rfg_readdata_valid  in  1  read data valid (any latency ≥1 after rfg_read)
- busy  out  1  high in every state except CMD
- err_cmd  out  1  one-cycle pulse: reserved opcode received
- err_timeout  out  1  one-cycle pulse: command aborted on timeout

Behaviour:
- Reset (resn=0 at clk edge, synchronous): state=CMD. All strobes, m_axis_tvalid, m_axis_tlast, err_* and busy are 0. rfg_address, rfg_writedata, m_axis_tdata and m_axis_tdest are 0. Counters are cleared. Reset mid-command discards the command silently.
- Command byte: bits[7:6] op (00 NOP, 01 WRITE, 10 READ, 11 reserved); bit5 AUTO_INC; bits[4:0] ignored. It is followed by an address byte (zero-extended or truncated to ADDR_WIDTH) and a length byte N (0..255).
- s_axis_tready=1 in CMD, ADDR, LEN and WDATA; 0 in RREQ, RWAIT and RSEND.
- CMD: on handshake, latch op, AUTO_INC and tid into m_axis_tdest.
  - NOP: stay in CMD.
  - Reserved: pulse err_cmd the next cycle and stay in CMD.
  - WRITE/READ: go to ADDR.
- ADDR: on handshake, load rfg_address and go to LEN.
- LEN: on handshake, load remaining count = N.
  - N=0: return to CMD with no access.
  - Else WRITE goes to WDATA, READ goes to RREQ.
- WDATA: on handshake, the next cycle has rfg_write=1 for exactly one cycle, rfg_writedata=byte, and rfg_address=current address.
  - The cycle after the strobe, the address increments if AUTO_INC and remaining decrements.
  - At remaining=0, go to CMD.
  - Back-to-back bytes produce back-to-back strobes; addresses step by 1 per strobe.
- RREQ: rfg_read=1 for one cycle, then go to RWAIT.
- RWAIT: on rfg_readdata_valid, capture rfg_readdata into m_axis_tdata, set m_axis_tvalid=1, set m_axis_tlast=(remaining==1), and go to RSEND.
- RSEND: hold tdata/tvalid/tlast stable until m_axis_tready. On handshake:
  - deassert tvalid/tlast;
  - increment the address if AUTO_INC;
  - decrement remaining;
  - go to RREQ, or to CMD if remaining=0.
- rfg_readdata_valid outside RWAIT is ignored.
- Timeout: an idle counter runs in ADDR, LEN, WDATA (no s_axis handshake) and RWAIT (no readdata_valid). It is cleared on every handshake or valid.
  - When it reaches TIMEOUT, pulse err_timeout for one cycle and go to CMD.
  - No timeout in CMD or RSEND; backpressure is legal indefinitely.
- Address wrap: the all-ones address increments to 0.
- A simultaneous readdata_valid and timeout expiry in the same cycle is treated as valid data; no timeout is raised.

Test Plan:
- Bytes 0x60,0x10,0x03,0xAA,0xBB,0xCC, continuous valid -> three rfg_write pulses at addr 0x10/0x11/0x12 with data AA/BB/CC, then busy=0.
- Bytes 0x80,0x20,0x02, readdata=0x5A then 0xA5 at 3-cycle latency, tid=0x07 -> two rfg_read at addr 0x20 both times (no AUTO_INC); m_axis outputs 5A then A5 with tlast on A5 only, and tdest=0x07.
- Read 0xA0,0xFF,0x02 with m_axis_tready low for 20 cycles -> tvalid and tdata held, no err_timeout; addresses 0xFF then 0x00.
- Bytes 0xC0 then 0x00 -> err_cmd pulse, stays in CMD; a following 0x40,0x05,0x00 produces no rfg_write and returns to CMD.
- TIMEOUT=16: 0x40,0x01 then stall -> err_timeout exactly 16 cycles after the last handshake, state CMD; a subsequent full write executes correctly.
- resn low for 1 cycle during WDATA of a 4-byte write after 2 bytes -> no further strobes; the next byte is treated as a command.
